md_sequencer: RTL and testbench
===============================

// Module: md_sequencer
// PURPOSE
//  Sequences the shared HI/LO multiply/divide resource for the execute stage.
//  Accepts one MD op per start pulse and holds busy for a fixed latency.
//  Commits HI/LO at the end of the latency and raises a D-stage stall request
//  while the resource is occupied. A flush (interrupt) cancels an op issued in
//  the same cycle.
// PARAMETERS
//  MULT_CYCLES  5   busy cycles for mult/multu, valid range 1..15
//  DIV_CYCLES   10  busy cycles for div/divu, valid range 1..15
// PORTS
//  clk        in   1   clock; all state updates on the rising edge
//  reset      in   1   synchronous, active-high reset
//  flush      in   1   interrupt/exception flush; suppresses start in the same cycle
//  start      in   1   E-stage MD instruction valid this cycle
//  md_op      in   3   0 mult, 1 multu, 2 div, 3 divu, 4 mthi, 5 mtlo, 6-7 no-op
//  D1         in   32  forwarded rs operand (SrcA)
//  D2         in   32  forwarded rt operand
//  md_use_D   in   1   D-stage instruction reads or writes HI/LO or starts MD
//  Busy       out  1   operation in flight
//  stall_md   out  1   stall request for F/D, bubble into E
//  HI         out  32  architectural HI
//  LO         out  32  architectural LO
// BEHAVIOUR
//  - Reset: state=IDLE, cnt=0, Busy=0, HI=0, LO=0, pend_hi/pend_lo=0.
//  - go = start & ~flush. A start that arrives during flush has no effect.
//  - FSM states IDLE and RUN.
//  - IDLE, go with op 0-3:
//    - Latch pend_hi/pend_lo with the full 64-bit result computed from D1/D2.
//    - Load cnt with MULT_CYCLES or DIV_CYCLES and move to RUN.
//    - Busy=1 from the next cycle.
//  - IDLE, go with op 4 (mthi) or op 5 (mtlo):
//    - HI<=D1 (mthi) or LO<=D1 (mtlo) at the next edge.
//    - No Busy, stay in IDLE.
//  - RUN:
//    - cnt decrements each cycle.
//    - When cnt==1: HI<=pend_hi, LO<=pend_lo, Busy drops, return to IDLE.
//    - Busy is therefore high for exactly N cycles.
//  - Arithmetic:
//    - mult: signed 32x32->64. multu: unsigned.
//    - HI = product[63:32], LO = product[31:0].
//    - div: signed, quotient truncates toward zero, remainder takes the sign of
//      the dividend. LO = quotient, HI = remainder. divu: unsigned.
//  - Divide by zero: the op still runs DIV_CYCLES, but HI/LO are left unchanged at commit.
//  - Signed overflow 0x80000000 / -1: LO=0x80000000, HI=0.
//  - flush while in RUN does not abort. The issuing instruction has already retired
//    past E, so the op completes and commits.
//  - go while in RUN is illegal, because stall_md prevents it. If it occurs, it is
//    ignored and the in-flight op continues.
//  - stall_md = md_use_D & (Busy | (go & md_op<=3)).
//    - Purely combinational.
//    - Deasserts in the cycle HI/LO commit becomes visible.
//  - HI/LO outputs are registers; they are never exposed before commit.
//  - reset asserted during RUN wins: everything returns to reset values next edge.
// STRUCTURE
//  - Shared package/header: MD_MULT/MD_MULTU/MD_DIV/MD_DIVU/MD_MTHI/MD_MTLO codes,
//    state encodings ST_IDLE/ST_RUN.
//  - One sub-module, md_arith: combinational 64-bit {hi,lo} result from op/D1/D2,
//    including the div-by-zero flag.
//  - The FSM, counter and HI/LO registers live in md_sequencer.
// TESTING
//  1. mult D1=-3, D2=7 -> Busy high 5 cycles; then HI=0xFFFFFFFF, LO=0xFFFFFFEB.
//  2. divu D1=100, D2=7 -> Busy high 10 cycles; then LO=14, HI=2.
//     Signed div -7/2 -> LO=0xFFFFFFFD, HI=0xFFFFFFFF.
//  3. mthi D1=0x12345678 -> HI updated next cycle, Busy never asserts.
//     mtlo likewise updates LO.
//  4. start=1, flush=1 with op mult -> Busy stays 0, HI/LO unchanged, stall_md=0
//     even with md_use_D=1.
//  5. md_use_D=1 on the start cycle of div -> stall_md high that cycle and for 10
//     Busy cycles, low after commit. div by 0 leaves HI/LO at their prior values.
//  6. reset pulse at cnt=3 of a mult -> Busy=0, HI=LO=0 next cycle, no later commit.
//     flush at cnt=3 -> op still commits.

Source files
------------

// File: rtl/md_sequencer_pkg.sv
// Shared definitions for the HI/LO multiply/divide sequencer.
//   - MD_* : md_op encodings driven by the E stage
//   - md_state_e : sequencer FSM states
//   - DATA_W : operand / HI / LO width
//   - is_long_op : true for ops that occupy the resource for a latency
package md_sequencer_pkg;

  localparam int DATA_W = 32;

  localparam logic [2:0] MD_MULT  = 3'd0;
  localparam logic [2:0] MD_MULTU = 3'd1;
  localparam logic [2:0] MD_DIV   = 3'd2;
  localparam logic [2:0] MD_DIVU  = 3'd3;
  localparam logic [2:0] MD_MTHI  = 3'd4;
  localparam logic [2:0] MD_MTLO  = 3'd5;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } md_state_e;

  function automatic logic is_long_op(input logic [2:0] op);
    return (op <= MD_DIVU);
  endfunction

endpackage

// File: rtl/md_arith.sv
// Combinational multiply/divide datapath.
//   op       in  3       md_op code
//   d1, d2   in  DATA_W  operands (d1 = rs / dividend, d2 = rt / divisor)
//   hi, lo   out DATA_W  result: product[63:32]/[31:0], or remainder/quotient
//   div_zero out 1       div/divu with a zero divisor; result must not commit
module md_arith
  import md_sequencer_pkg::*;
(
  input  logic [2:0]        op,
  input  logic [DATA_W-1:0] d1,
  input  logic [DATA_W-1:0] d2,
  output logic [DATA_W-1:0] hi,
  output logic [DATA_W-1:0] lo,
  output logic              div_zero
);

  localparam logic [DATA_W-1:0] MIN_NEG = {1'b1, {(DATA_W-1){1'b0}}};

  // Signed divide with the two hardware hazards pinned down: a zero divisor
  // is replaced by 1 (result is discarded anyway) and MIN_NEG / -1 saturates
  // the quotient to MIN_NEG with a zero remainder instead of overflowing.
  function automatic logic [2*DATA_W-1:0] sdiv_sat(input logic signed [DATA_W-1:0] a,
                                                   input logic signed [DATA_W-1:0] b);
    logic signed [DATA_W-1:0] den;
    logic signed [DATA_W-1:0] q;
    logic signed [DATA_W-1:0] r;
    den = (b == '0) ? DATA_W'(1) : b;
    if (a == $signed(MIN_NEG) && b == -1) begin
      q = $signed(MIN_NEG);
      r = '0;
    end else begin
      q = a / den;
      r = a % den;
    end
    return {r, q};
  endfunction

  function automatic logic [2*DATA_W-1:0] udiv_safe(input logic [DATA_W-1:0] a,
                                                    input logic [DATA_W-1:0] b);
    logic [DATA_W-1:0] den;
    den = (b == '0) ? DATA_W'(1) : b;
    return {a % den, a / den};
  endfunction

  logic signed [2*DATA_W-1:0] a_ext;
  logic signed [2*DATA_W-1:0] b_ext;
  logic signed [2*DATA_W-1:0] prod_s;
  logic        [2*DATA_W-1:0] prod_u;
  logic        [2*DATA_W-1:0] res;

  assign a_ext  = $signed({{DATA_W{d1[DATA_W-1]}}, d1});
  assign b_ext  = $signed({{DATA_W{d2[DATA_W-1]}}, d2});
  assign prod_s = a_ext * b_ext;
  assign prod_u = {{DATA_W{1'b0}}, d1} * {{DATA_W{1'b0}}, d2};

  always_comb begin
    res = '0;
    case (op)
      MD_MULT:  res = prod_s;
      MD_MULTU: res = prod_u;
      MD_DIV:   res = sdiv_sat($signed(d1), $signed(d2));
      MD_DIVU:  res = udiv_safe(d1, d2);
      default:  res = '0;
    endcase
  end

  assign hi       = res[2*DATA_W-1:DATA_W];
  assign lo       = res[DATA_W-1:0];
  assign div_zero = ((op == MD_DIV) || (op == MD_DIVU)) && (d2 == '0);

endmodule

// File: rtl/md_sequencer.sv
// Sequencer for the shared HI/LO multiply/divide resource.
//   clk       in   1   clock
//   reset     in   1   synchronous active-high reset
//   flush     in   1   suppresses a start in the same cycle
//   start     in   1   E-stage MD instruction valid
//   md_op     in   3   operation code (see md_sequencer_pkg)
//   D1, D2    in   32  forwarded rs / rt operands
//   md_use_D  in   1   D-stage instruction touches HI/LO or the MD unit
//   Busy      out  1   long operation in flight
//   stall_md  out  1   stall request for F/D
//   HI, LO    out  32  architectural HI/LO registers
// The result is computed in the issue cycle and parked in pend_hi/pend_lo; it
// only reaches HI/LO when the latency counter expires.
module md_sequencer
  import md_sequencer_pkg::*;
#(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              flush,
  input  logic              start,
  input  logic [2:0]        md_op,
  input  logic [DATA_W-1:0] D1,
  input  logic [DATA_W-1:0] D2,
  input  logic              md_use_D,
  output logic              Busy,
  output logic              stall_md,
  output logic [DATA_W-1:0] HI,
  output logic [DATA_W-1:0] LO
);

  md_state_e         state;
  logic [3:0]        cnt;
  logic [DATA_W-1:0] pend_hi;
  logic [DATA_W-1:0] pend_lo;
  logic              pend_dz;

  logic              go;
  logic [DATA_W-1:0] res_hi;
  logic [DATA_W-1:0] res_lo;
  logic              res_dz;
  logic              is_mult;

  assign go      = start & ~flush;
  assign is_mult = (md_op == MD_MULT) || (md_op == MD_MULTU);

  md_arith u_arith (
    .op       (md_op),
    .d1       (D1),
    .d2       (D2),
    .hi       (res_hi),
    .lo       (res_lo),
    .div_zero (res_dz)
  );

  // Busy is registered, so the stall drops in the same cycle the committed
  // HI/LO become visible.
  assign stall_md = md_use_D & (Busy | (go & is_long_op(md_op)));

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= ST_IDLE;
      cnt     <= '0;
      Busy    <= 1'b0;
      HI      <= '0;
      LO      <= '0;
      pend_hi <= '0;
      pend_lo <= '0;
      pend_dz <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (go) begin
            if (is_long_op(md_op)) begin
              pend_hi <= res_hi;
              pend_lo <= res_lo;
              pend_dz <= res_dz;
              cnt     <= is_mult ? 4'(MULT_CYCLES) : 4'(DIV_CYCLES);
              Busy    <= 1'b1;
              state   <= ST_RUN;
            end else if (md_op == MD_MTHI) begin
              HI <= D1;
            end else if (md_op == MD_MTLO) begin
              LO <= D1;
            end
          end
        end
        // Flush and any stray start are ignored here: the issuing
        // instruction has already left E, so the op must complete.
        ST_RUN: begin
          if (cnt == 4'd1) begin
            if (!pend_dz) begin
              HI <= pend_hi;
              LO <= pend_lo;
            end
            cnt   <= '0;
            Busy  <= 1'b0;
            state <= ST_IDLE;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        default: begin
          state <= ST_IDLE;
          Busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_md_sequencer.sv
module tb_md_sequencer;
  import md_sequencer_pkg::*;

  logic        clk = 1'b0;
  logic        reset, flush, start, md_use_D;
  logic [2:0]  md_op;
  logic [31:0] D1, D2;
  logic        Busy, stall_md;
  logic [31:0] HI, LO;

  int checks   = 0;
  int failures = 0;
  logic [31:0] mdl_hi, mdl_lo;

  always #5 clk = ~clk;

  md_sequencer #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
    .clk(clk), .reset(reset), .flush(flush), .start(start), .md_op(md_op),
    .D1(D1), .D2(D2), .md_use_D(md_use_D), .Busy(Busy), .stall_md(stall_md),
    .HI(HI), .LO(LO)
  );

  typedef struct {
    string       name;
    logic [2:0]  op;
    logic [31:0] d1;
    logic [31:0] d2;
    logic [31:0] hi;
    logic [31:0] lo;
    int          cyc;
    logic        keep;   // divide by zero: HI/LO must stay at prior values
  } vec_t;

  vec_t vecs[9];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic run_vec(input vec_t v);
    int n;
    logic [31:0] eh, el;
    eh = v.keep ? mdl_hi : v.hi;
    el = v.keep ? mdl_lo : v.lo;
    start = 1'b1; md_op = v.op; D1 = v.d1; D2 = v.d2; md_use_D = 1'b1;
    #1;
    chk({v.name, "_stall_issue"}, 32'(stall_md), 32'd1);
    step();
    start = 1'b0;
    n = 0;
    while (Busy === 1'b1 && n < 40) begin
      if (n == 0) begin
        chk({v.name, "_stall_busy"}, 32'(stall_md), 32'd1);
        chk({v.name, "_hi_hold"}, HI, mdl_hi);
        chk({v.name, "_lo_hold"}, LO, mdl_lo);
      end
      n++;
      step();
    end
    chk({v.name, "_busy_cycles"}, 32'(n), 32'(v.cyc));
    chk({v.name, "_hi"}, HI, eh);
    chk({v.name, "_lo"}, LO, el);
    chk({v.name, "_stall_after"}, 32'(stall_md), 32'd0);
    md_use_D = 1'b0;
    mdl_hi = eh;
    mdl_lo = el;
  endtask

  initial begin
    int n;
    vecs[0] = '{"mult_neg",  MD_MULT,  32'hFFFFFFFD, 32'd7,        32'hFFFFFFFF, 32'hFFFFFFEB, 5,  1'b0};
    vecs[1] = '{"divu",      MD_DIVU,  32'd100,      32'd7,        32'd2,        32'd14,       10, 1'b0};
    vecs[2] = '{"div_neg",   MD_DIV,   32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 32'hFFFFFFFD, 10, 1'b0};
    vecs[3] = '{"multu_max", MD_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 5,  1'b0};
    vecs[4] = '{"div_zero",  MD_DIV,   32'd55,       32'd0,        32'd0,        32'd0,        10, 1'b1};
    vecs[5] = '{"div_ovf",   MD_DIV,   32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, 10, 1'b0};
    vecs[6] = '{"mult_min",  MD_MULT,  32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000, 5,  1'b0};
    vecs[7] = '{"div_negd",  MD_DIV,   32'd7,        32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD, 10, 1'b0};
    vecs[8] = '{"divu_zero", MD_DIVU,  32'd9,        32'd0,        32'd0,        32'd0,        10, 1'b1};

    reset = 1'b1; flush = 1'b0; start = 1'b0; md_use_D = 1'b0;
    md_op = 3'd7; D1 = '0; D2 = '0;
    mdl_hi = '0; mdl_lo = '0;
    step();
    step();
    reset = 1'b0;
    #1;
    chk("reset_busy", 32'(Busy), 32'd0);
    chk("reset_hi", HI, 32'd0);
    chk("reset_lo", LO, 32'd0);
    md_use_D = 1'b1;
    #1;
    chk("reset_stall", 32'(stall_md), 32'd0);

    // mthi / mtlo: single-cycle, no Busy, no stall
    start = 1'b1; md_op = MD_MTHI; D1 = 32'h12345678;
    #1;
    chk("mthi_stall", 32'(stall_md), 32'd0);
    step();
    start = 1'b0;
    chk("mthi_hi", HI, 32'h12345678);
    chk("mthi_lo", LO, 32'd0);
    chk("mthi_busy", 32'(Busy), 32'd0);
    start = 1'b1; md_op = MD_MTLO; D1 = 32'hCAFEF00D;
    step();
    start = 1'b0;
    chk("mtlo_lo", LO, 32'hCAFEF00D);
    chk("mtlo_hi", HI, 32'h12345678);
    step();
    chk("mtlo_busy", 32'(Busy), 32'd0);
    mdl_hi = 32'h12345678;
    mdl_lo = 32'hCAFEF00D;

    // start together with flush has no effect
    start = 1'b1; flush = 1'b1; md_op = MD_MULT; D1 = 32'd3; D2 = 32'd4; md_use_D = 1'b1;
    #1;
    chk("flush_stall", 32'(stall_md), 32'd0);
    step();
    start = 1'b0; flush = 1'b0;
    chk("flush_busy", 32'(Busy), 32'd0);
    for (int i = 0; i < 6; i++) step();
    chk("flush_busy_late", 32'(Busy), 32'd0);
    chk("flush_hi", HI, mdl_hi);
    chk("flush_lo", LO, mdl_lo);
    md_use_D = 1'b0;

    for (int i = 0; i < 9; i++) run_vec(vecs[i]);

    // reset in the middle of a mult wins and cancels the commit
    start = 1'b1; md_op = MD_MULT; D1 = 32'hFFFFFFFF; D2 = 32'd1;
    step();
    start = 1'b0;
    step();
    step();
    reset = 1'b1;
    step();
    reset = 1'b0;
    chk("rstrun_busy", 32'(Busy), 32'd0);
    chk("rstrun_hi", HI, 32'd0);
    chk("rstrun_lo", LO, 32'd0);
    for (int i = 0; i < 8; i++) step();
    chk("rstrun_busy_late", 32'(Busy), 32'd0);
    chk("rstrun_hi_late", HI, 32'd0);
    chk("rstrun_lo_late", LO, 32'd0);

    // flush during RUN does not abort; stray start during RUN is ignored
    start = 1'b1; md_op = MD_MULT; D1 = 32'hFFFFFFFE; D2 = 32'd3;
    step();
    start = 1'b0;
    step();
    step();
    flush = 1'b1;
    step();
    flush = 1'b0;
    chk("flushrun_busy", 32'(Busy), 32'd1);
    start = 1'b1; md_op = MD_MTHI; D1 = 32'hDEADBEEF;
    step();
    start = 1'b0;
    chk("strayrun_hi", HI, 32'd0);
    n = 0;
    while (Busy === 1'b1 && n < 40) begin
      n++;
      step();
    end
    chk("flushrun_remaining", 32'(n), 32'd1);
    chk("flushrun_hi", HI, 32'hFFFFFFFF);
    chk("flushrun_lo", LO, 32'hFFFFFFFA);
    step();
    chk("flushrun_idle", 32'(Busy), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
